// File: rtl/aes_dec_pkg.sv
// -----------------------------------------------------------------------------
// aes_dec_pkg
// Shared types and constants for the AES-256 decryption round datapath.
//   state_t      : 128-bit AES state, byte 0 in bits [127:120]
//   col_t        : one 32-bit state column, row 0 in bits [31:24]
//   NUM_COLS     : columns per state
//   fsm_state_e  : sequencing states of the InvMixColumns stage
// -----------------------------------------------------------------------------
package aes_dec_pkg;

    typedef logic [127:0] state_t;
    typedef logic [31:0]  col_t;

    localparam int NUM_COLS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_state_e;

endpackage

// File: rtl/aes_inv_mix_col_seq_mix_column_helper.sv
// -----------------------------------------------------------------------------
// MixColumnHelper
// Combinational InvMixColumns transform of a single AES column in GF(2^8)
// with the AES polynomial x^8 + x^4 + x^3 + x + 1.
// Ports:
//   rc  in  32  input column, rc[31:24] = row 0
//   mc  out 32  transformed column, same byte order
// -----------------------------------------------------------------------------
module MixColumnHelper
    import aes_dec_pkg::*;
(
    input  col_t rc,
    output col_t mc
);

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul09(input logic [7:0] b);
        return xt(xt(xt(b))) ^ b;
    endfunction

    function automatic logic [7:0] mul0b(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(b) ^ b;
    endfunction

    function automatic logic [7:0] mul0d(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
    endfunction

    function automatic logic [7:0] mul0e(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
    endfunction

    logic [7:0] a0, a1, a2, a3;

    assign a0 = rc[31:24];
    assign a1 = rc[23:16];
    assign a2 = rc[15:8];
    assign a3 = rc[7:0];

    assign mc[31:24] = mul0e(a0) ^ mul0b(a1) ^ mul0d(a2) ^ mul09(a3);
    assign mc[23:16] = mul09(a0) ^ mul0e(a1) ^ mul0b(a2) ^ mul0d(a3);
    assign mc[15:8]  = mul0d(a0) ^ mul09(a1) ^ mul0e(a2) ^ mul0b(a3);
    assign mc[7:0]   = mul0b(a0) ^ mul0d(a1) ^ mul09(a2) ^ mul0e(a3);

endmodule

// File: rtl/aes_inv_mix_col_seq.sv
// -----------------------------------------------------------------------------
// aes_inv_mix_col_seq
// AddRoundKey + InvMixColumns stage of the AES-256 decryption round. The
// XOR of state and key is captured on acceptance, then COLS_PER_CYCLE columns
// per cycle are pushed through MixColumnHelper lanes into the result register.
//
// Optional feature macro: INV_MIX_BYPASS_EN
//   When defined, last_round exists; last_round=1 at acceptance writes the
//   key-XORed state straight to the result and skips RUN.
//
// Parameters:
//   COLS_PER_CYCLE  columns per RUN cycle (1, 2 or 4)
// Ports:
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-high reset
//   in_valid    in   upstream offers state_in/round_key
//   in_ready    out  stage idle and out of reset
//   state_in    in   128-bit state, byte 0 = [127:120]
//   round_key   in   128-bit round key, same byte order
//   last_round  in   (INV_MIX_BYPASS_EN only) skip InvMixColumns
//   out_valid   out  state_out holds a finished result
//   out_ready   in   downstream accepts
//   state_out   out  128-bit result
//   busy        out  stage not idle
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for in_valid; in_ready high
// RUN   | mixing columns col .. col+COLS_PER_CYCLE-1 each cycle
// DONE  | result held on state_out with out_valid until out_ready
// -----------------------------------------------------------------------------
module aes_inv_mix_col_seq
    import aes_dec_pkg::*;
#(
    parameter int unsigned COLS_PER_CYCLE = 1
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   in_valid,
    output logic   in_ready,
    input  state_t state_in,
    input  state_t round_key,
`ifdef INV_MIX_BYPASS_EN
    input  logic   last_round,
`endif
    output logic   out_valid,
    input  logic   out_ready,
    output state_t state_out,
    output logic   busy
);

    fsm_state_e state_q, state_d;
    logic [1:0] col_q, col_d;
    state_t     work_q, work_d;
    state_t     res_q, res_d;

    col_t work_cols [NUM_COLS];
    col_t lane_in   [COLS_PER_CYCLE];
    col_t lane_out  [COLS_PER_CYCLE];
    logic col_we    [NUM_COLS];
    col_t col_wd    [NUM_COLS];
    logic last_col;

    // Column select: lane j works on column col+j.
    always_comb begin
        for (int c = 0; c < NUM_COLS; c++) begin
            work_cols[c] = work_q[127-32*c -: 32];
        end
        for (int j = 0; j < int'(COLS_PER_CYCLE); j++) begin
            lane_in[j] = work_cols[col_q + 2'(j)];
        end
    end

    for (genvar j = 0; j < int'(COLS_PER_CYCLE); j++) begin : g_lane
        MixColumnHelper u_mix (
            .rc (lane_in[j]),
            .mc (lane_out[j])
        );
    end

    // Per-column write enables for the result register.
    always_comb begin
        for (int c = 0; c < NUM_COLS; c++) begin
            col_we[c] = 1'b0;
            col_wd[c] = lane_out[0];
        end
        if (state_q == RUN) begin
            for (int j = 0; j < int'(COLS_PER_CYCLE); j++) begin
                col_we[col_q + 2'(j)] = 1'b1;
                col_wd[col_q + 2'(j)] = lane_out[j];
            end
        end
    end

    // Widened so that col + COLS_PER_CYCLE == 4 does not alias to 0.
    assign last_col = (({1'b0, col_q} + 3'(COLS_PER_CYCLE)) == 3'(NUM_COLS));

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        work_d  = work_q;
        res_d   = res_q;

        for (int c = 0; c < NUM_COLS; c++) begin
            if (col_we[c]) begin
                res_d[127-32*c -: 32] = col_wd[c];
            end
        end

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d = state_in ^ round_key;
                    col_d  = 2'd0;
`ifdef INV_MIX_BYPASS_EN
                    if (last_round) begin
                        res_d   = state_in ^ round_key;
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
`else
                    state_d = RUN;
`endif
                end
            end
            RUN: begin
                if (last_col) begin
                    col_d   = 2'd0;
                    state_d = DONE;
                end else begin
                    col_d = col_q + 2'(COLS_PER_CYCLE);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                col_d   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            col_q   <= 2'd0;
            work_q  <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            work_q  <= work_d;
            res_q   <= res_d;
        end
    end

    // rst gates in_ready so nothing is offered while reset is held.
    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign state_out = res_q;

endmodule

// File: tb/tb_aes_inv_mix_col_seq.sv
// -----------------------------------------------------------------------------
// tb_aes_inv_mix_col_seq
// Three stage instances (1, 2 and 4 columns per cycle) share all inputs and
// run in lockstep; each scenario task compares their outputs against
// hand-computed AES InvMixColumns vectors and expected latencies.
// Optional macro: INV_MIX_BYPASS_EN enables the last-round bypass scenario.
// -----------------------------------------------------------------------------
module tb_aes_inv_mix_col_seq;

    localparam logic [127:0] ZK_IN  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] XK_IN  = 128'h71b25e43_6023a762_fefefefe_39393939;
    localparam logic [127:0] ALL_FF = {128{1'b1}};
    localparam logic [127:0] EXP_MC = 128'hdb135345_f20a225c_01010101_c6c6c6c6;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         out_ready;
    logic [127:0] state_in;
    logic [127:0] round_key;
`ifdef INV_MIX_BYPASS_EN
    logic         last_round;
`endif

    logic         in_ready1, out_valid1, busy1;
    logic         in_ready2, out_valid2, busy2;
    logic         in_ready4, out_valid4, busy4;
    logic [127:0] state_out1, state_out2, state_out4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    aes_inv_mix_col_seq #(.COLS_PER_CYCLE(1)) u_c1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready1),
        .state_in  (state_in),
        .round_key (round_key),
`ifdef INV_MIX_BYPASS_EN
        .last_round(last_round),
`endif
        .out_valid (out_valid1),
        .out_ready (out_ready),
        .state_out (state_out1),
        .busy      (busy1)
    );

    aes_inv_mix_col_seq #(.COLS_PER_CYCLE(2)) u_c2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready2),
        .state_in  (state_in),
        .round_key (round_key),
`ifdef INV_MIX_BYPASS_EN
        .last_round(last_round),
`endif
        .out_valid (out_valid2),
        .out_ready (out_ready),
        .state_out (state_out2),
        .busy      (busy2)
    );

    aes_inv_mix_col_seq #(.COLS_PER_CYCLE(4)) u_c4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready4),
        .state_in  (state_in),
        .round_key (round_key),
`ifdef INV_MIX_BYPASS_EN
        .last_round(last_round),
`endif
        .out_valid (out_valid4),
        .out_ready (out_ready),
        .state_out (state_out4),
        .busy      (busy4)
    );

    // Offer one block; returns just after the acceptance edge E0.
    task automatic issue(input logic [127:0] s, input logic [127:0] k);
        state_in  = s;
        round_key = k;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
    endtask

    // Edges after E0 until each instance shows out_valid; -1 if it never did.
    task automatic wait_done(output int l1, output int l2, output int l4);
        l1 = -1; l2 = -1; l4 = -1;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk); #1;
            if (out_valid1 && l1 < 0) l1 = e;
            if (out_valid2 && l2 < 0) l2 = e;
            if (out_valid4 && l4 < 0) l4 = e;
            if (l1 >= 0 && l2 >= 0 && l4 >= 0) break;
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        checks++; if (in_ready1 !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b want=0", in_ready1); end
        checks++; if (out_valid1 !== 1'b0 || out_valid2 !== 1'b0 || out_valid4 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b%b%b want=000", out_valid1, out_valid2, out_valid4); end
        checks++; if (busy1 !== 1'b0 || busy4 !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b%b want=00", busy1, busy4); end
        checks++; if (state_out1 !== 128'h0) begin errors++; $display("FAIL reset_state_out got=%h want=0", state_out1); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (in_ready1 !== 1'b1 || in_ready2 !== 1'b1 || in_ready4 !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready got=%b%b%b want=111", in_ready1, in_ready2, in_ready4); end
        @(posedge clk); #1;
    endtask

    task automatic test_zero_key();
        int l1, l2, l4;
        issue(ZK_IN, 128'h0);
        checks++; if (in_ready1 !== 1'b0 || busy1 !== 1'b1) begin errors++; $display("FAIL zk_run_flags in_ready=%b busy=%b want in_ready=0 busy=1", in_ready1, busy1); end
        wait_done(l1, l2, l4);
        checks++; if (l1 != 4) begin errors++; $display("FAIL zk_latency_c1 got=%0d want=4", l1); end
        checks++; if (l2 != 2) begin errors++; $display("FAIL zk_latency_c2 got=%0d want=2", l2); end
        checks++; if (l4 != 1) begin errors++; $display("FAIL zk_latency_c4 got=%0d want=1", l4); end
        checks++; if (state_out1 !== EXP_MC) begin errors++; $display("FAIL zk_out_c1 got=%h want=%h", state_out1, EXP_MC); end
        checks++; if (state_out2 !== EXP_MC) begin errors++; $display("FAIL zk_out_c2 got=%h want=%h", state_out2, EXP_MC); end
        checks++; if (state_out4 !== EXP_MC) begin errors++; $display("FAIL zk_out_c4 got=%h want=%h", state_out4, EXP_MC); end
        drain();
        checks++; if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0 || busy1 !== 1'b0) begin errors++; $display("FAIL zk_after_drain in_ready=%b out_valid=%b busy=%b want 1 0 0", in_ready1, out_valid1, busy1); end
    endtask

    task automatic test_key_xor();
        int l1, l2, l4;
        issue(XK_IN, ALL_FF);
        wait_done(l1, l2, l4);
        checks++; if (l1 != 4 || l2 != 2 || l4 != 1) begin errors++; $display("FAIL xk_latency got=%0d/%0d/%0d want=4/2/1", l1, l2, l4); end
        checks++; if (state_out1 !== EXP_MC) begin errors++; $display("FAIL xk_out_c1 got=%h want=%h", state_out1, EXP_MC); end
        checks++; if (state_out2 !== EXP_MC) begin errors++; $display("FAIL xk_out_c2 got=%h want=%h", state_out2, EXP_MC); end
        checks++; if (state_out4 !== EXP_MC) begin errors++; $display("FAIL xk_out_c4 got=%h want=%h", state_out4, EXP_MC); end
        drain();
    endtask

    task automatic test_backpressure();
        int l1, l2, l4;
        issue(ZK_IN, 128'h0);
        wait_done(l1, l2, l4);
        for (int i = 0; i < 5; i++) begin
            state_in  = 128'h00112233_44556677_8899aabb_ccddeeff;
            round_key = 128'h0;
            in_valid  = 1'b1;
            @(posedge clk); #1;
            checks++; if (out_valid1 !== 1'b1 || out_valid4 !== 1'b1) begin errors++; $display("FAIL bp_out_valid cyc=%0d got=%b%b want=11", i, out_valid1, out_valid4); end
            checks++; if (state_out1 !== EXP_MC || state_out4 !== EXP_MC) begin errors++; $display("FAIL bp_state_out cyc=%0d got=%h/%h want=%h", i, state_out1, state_out4, EXP_MC); end
            checks++; if (in_ready1 !== 1'b0 || in_ready2 !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc=%0d got=%b%b want=00", i, in_ready1, in_ready2); end
        end
        in_valid = 1'b0;
        drain();
        checks++; if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin errors++; $display("FAIL bp_transfer out_valid=%b in_ready=%b want 0 1", out_valid1, in_ready1); end
        @(posedge clk); #1;
        checks++; if (busy1 !== 1'b0 || busy2 !== 1'b0 || busy4 !== 1'b0) begin errors++; $display("FAIL bp_idle_busy got=%b%b%b want=000", busy1, busy2, busy4); end
    endtask

    task automatic test_reset_mid_run();
        int l1, l2, l4;
        issue(ZK_IN, 128'h0);
        @(posedge clk);
        @(posedge clk); #1;
        checks++; if (busy1 !== 1'b1 || out_valid1 !== 1'b0) begin errors++; $display("FAIL rst_pre_busy busy=%b out_valid=%b want 1 0", busy1, out_valid1); end
        rst = 1'b1;
        #1;
        checks++; if (out_valid1 !== 1'b0 || out_valid2 !== 1'b0 || out_valid4 !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid got=%b%b%b want=000", out_valid1, out_valid2, out_valid4); end
        checks++; if (state_out1 !== 128'h0 || state_out2 !== 128'h0 || state_out4 !== 128'h0) begin errors++; $display("FAIL rst_mid_state_out got=%h want=0", state_out1); end
        checks++; if (busy1 !== 1'b0 || in_ready1 !== 1'b0) begin errors++; $display("FAIL rst_mid_busy busy=%b in_ready=%b want 0 0", busy1, in_ready1); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (in_ready1 !== 1'b1) begin errors++; $display("FAIL rst_mid_release_in_ready got=%b want=1", in_ready1); end
        @(posedge clk); #1;
        checks++; if (out_valid1 !== 1'b0 || busy1 !== 1'b0) begin errors++; $display("FAIL rst_mid_discard out_valid=%b busy=%b want 0 0", out_valid1, busy1); end
        issue(ZK_IN, 128'h0);
        wait_done(l1, l2, l4);
        checks++; if (l1 != 4) begin errors++; $display("FAIL rst_rerun_latency got=%0d want=4", l1); end
        checks++; if (state_out1 !== EXP_MC) begin errors++; $display("FAIL rst_rerun_out got=%h want=%h", state_out1, EXP_MC); end
        drain();
    endtask

`ifdef INV_MIX_BYPASS_EN
    task automatic test_bypass();
        int l1, l2, l4;
        logic [127:0] exp_bp;
        exp_bp = 128'hffeeddcc_44556677_77665544_ccddeeff;
        last_round = 1'b1;
        issue(128'h00112233_44556677_8899aabb_ccddeeff,
              128'hffffffff_00000000_ffffffff_00000000);
        last_round = 1'b0;
        wait_done(l1, l2, l4);
        checks++; if (l1 != 1 || l2 != 1 || l4 != 1) begin errors++; $display("FAIL bypass_latency got=%0d/%0d/%0d want=1/1/1", l1, l2, l4); end
        checks++; if (state_out1 !== exp_bp) begin errors++; $display("FAIL bypass_out_c1 got=%h want=%h", state_out1, exp_bp); end
        checks++; if (state_out4 !== exp_bp) begin errors++; $display("FAIL bypass_out_c4 got=%h want=%h", state_out4, exp_bp); end
        drain();
        issue(ZK_IN, 128'h0);
        wait_done(l1, l2, l4);
        checks++; if (l1 != 4 || state_out1 !== EXP_MC) begin errors++; $display("FAIL bypass_off_normal lat=%0d out=%h want 4 %h", l1, state_out1, EXP_MC); end
        drain();
    endtask
`endif

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        state_in  = 128'h0;
        round_key = 128'h0;
`ifdef INV_MIX_BYPASS_EN
        last_round = 1'b0;
`endif
        test_reset();
        test_zero_key();
        test_key_xor();
        test_backpressure();
        test_reset_mid_run();
`ifdef INV_MIX_BYPASS_EN
        test_bypass();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
